// File: rtl/nv_nvdla_cacc_abuf_arbiter.sv
// Shares the assembly-buffer read port between the accumulate path (A) and the
// delivery drain (B), and routes each read response back to its requester.
module nv_nvdla_cacc_abuf_arbiter #(
  parameter int ABUF_AWIDTH = 6,
  parameter int ABUF_WIDTH  = 768,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   rd_a_valid,
  input  logic [ABUF_AWIDTH-1:0] rd_a_addr,
  output logic                   rd_a_ready,
  input  logic                   rd_b_valid,
  input  logic [ABUF_AWIDTH-1:0] rd_b_addr,
  output logic                   rd_b_ready,
  input  logic                   wr_en,
  input  logic [ABUF_AWIDTH-1:0] wr_addr,
  input  logic [ABUF_WIDTH-1:0]  wr_data,
  output logic                   abuf_rd_en,
  output logic [ABUF_AWIDTH-1:0] abuf_rd_addr,
  output logic                   abuf_wr_en,
  output logic [ABUF_AWIDTH-1:0] abuf_wr_addr,
  output logic [ABUF_WIDTH-1:0]  abuf_wr_data,
  input  logic [ABUF_WIDTH-1:0]  abuf_rd_data,
  output logic                   rsp_a_valid,
  output logic                   rsp_b_valid,
  output logic [ABUF_WIDTH-1:0]  rsp_data,
  output logic [CNT_WIDTH-1:0]   stall_cnt,
  input  logic                   stall_cnt_clr
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  logic prio;
  logic coll_a, coll_b;
  logic ok_a, ok_b;
  logic grant_a, grant_b;
  logic stall;
  logic vld_p0, id_p0;
  logic vld_p1, id_p1;

  assign abuf_wr_en   = wr_en;
  assign abuf_wr_addr = wr_addr;
  assign abuf_wr_data = wr_data;

  // A read may not hit the word being written this cycle; the write lands at the edge.
  assign coll_a = wr_en & (rd_a_addr == wr_addr);
  assign coll_b = wr_en & (rd_b_addr == wr_addr);
  assign ok_a   = rd_a_valid & ~coll_a;
  assign ok_b   = rd_b_valid & ~coll_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!prio) begin
      grant_a = ok_a;
      grant_b = ~ok_a & ok_b;
    end else begin
      grant_b = ok_b;
      grant_a = ~ok_b & ok_a;
    end
  end

  assign rd_a_ready   = grant_a;
  assign rd_b_ready   = grant_b;
  assign abuf_rd_en   = grant_a | grant_b;
  assign abuf_rd_addr = grant_a ? rd_a_addr : (grant_b ? rd_b_addr : '0);
  assign stall        = (rd_a_valid | rd_b_valid) & ~(grant_a | grant_b);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      prio <= 1'b0;
    end else if (grant_a) begin
      prio <= 1'b1;
    end else if (grant_b) begin
      prio <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Stage p0: tag captured alongside the SRAM read issue.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      vld_p0 <= 1'b0;
      id_p0  <= 1'b0;
    end else begin
      vld_p0 <= abuf_rd_en;
      id_p0  <= grant_b;
    end
  end

  // Stage p1: tag aligned with the SRAM output data.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      id_p1  <= id_p0;
    end
  end

  assign rsp_a_valid = vld_p1 & ~id_p1;
  assign rsp_b_valid = vld_p1 & id_p1;
  assign rsp_data    = abuf_rd_data;

endmodule

// File: tb/tb_nv_nvdla_cacc_abuf_arbiter.sv
// Directed bench for the abuf read arbiter with a 2-cycle-latency SRAM model.
module tb_nv_nvdla_cacc_abuf_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_v = 1'b0, b_v = 1'b0, we = 1'b0, clr = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0, wa = '0;
  logic [DW-1:0] wd = '0;
  logic          a_rdy, b_rdy, rd_en, mem_we;
  logic [AW-1:0] rd_addr, mem_wa;
  logic [DW-1:0] mem_wd, rd_data, rsp_data;
  logic          rsp_a, rsp_b;
  logic [CW-1:0] cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nv_nvdla_cacc_abuf_arbiter #(.ABUF_AWIDTH(AW), .ABUF_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .rd_a_valid(a_v),
    .rd_a_addr(a_addr),
    .rd_a_ready(a_rdy),
    .rd_b_valid(b_v),
    .rd_b_addr(b_addr),
    .rd_b_ready(b_rdy),
    .wr_en(we),
    .wr_addr(wa),
    .wr_data(wd),
    .abuf_rd_en(rd_en),
    .abuf_rd_addr(rd_addr),
    .abuf_wr_en(mem_we),
    .abuf_wr_addr(mem_wa),
    .abuf_wr_data(mem_wd),
    .abuf_rd_data(rd_data),
    .rsp_a_valid(rsp_a),
    .rsp_b_valid(rsp_b),
    .rsp_data(rsp_data),
    .stall_cnt(cnt),
    .stall_cnt_clr(clr)
  );

  // SRAM model: word i preloads to D000_00ii, read data appears two cycles after rd_en.
  logic [DW-1:0] mem [64];
  logic [DW-1:0] q0, q1;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hD000_0000 | DW'(i);
    end else if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    q0 <= mem[rd_addr];
    q1 <= q0;
  end
  assign rd_data = q1;

  typedef struct {
    logic          av;
    logic [AW-1:0] aa;
    logic          bv;
    logic [AW-1:0] ba;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ea;
    logic          eb;
    logic [AW-1:0] eaddr;
    logic          rsa;
    logic          rsb;
    logic [DW-1:0] ed;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int av, input int aa, input int bv, input int ba,
                              input int w, input int wadr, input logic [DW-1:0] wdat,
                              input int ea, input int eb, input int eaddr,
                              input int rsa, input int rsb, input logic [DW-1:0] ed,
                              input int ecnt);
    vec_t v;
    v.av = 1'(av);  v.aa = AW'(aa);  v.bv = 1'(bv);  v.ba = AW'(ba);
    v.we = 1'(w);   v.wa = AW'(wadr); v.wd = wdat;
    v.ea = 1'(ea);  v.eb = 1'(eb);   v.eaddr = AW'(eaddr);
    v.rsa = 1'(rsa); v.rsb = 1'(rsb); v.ed = ed; v.ecnt = CW'(ecnt);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input int aa, input logic bv, input int ba,
                       input logic w, input int wadr, input logic [DW-1:0] wdat);
    a_v = av; a_addr = AW'(aa); b_v = bv; b_addr = AW'(ba);
    we = w; wa = AW'(wadr); wd = wdat;
  endtask

  localparam logic [DW-1:0] W1 = 32'hC0DE_0001, W2 = 32'hC0DE_0002, W3 = 32'hC0DE_0003;
  localparam logic [DW-1:0] W4 = 32'hC0DE_0004, W5 = 32'hC0DE_0005, W6 = 32'hC0DE_0006;

  initial begin
    // A alone on addr 5 for four cycles, then drain.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,5,0,0, 0,0,0, 1,0,5, (i >= 2),0,32'hD000_0005, 0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1,0,32'hD000_0005, 0));
    // Both contending; prio points at B after the last A grant.
    tbl.push_back(mk(1,3,1,9, 0,0,0, 0,1,9, 0,0,0, 0));
    tbl.push_back(mk(1,3,1,9, 0,0,0, 1,0,3, 0,0,0, 0));
    tbl.push_back(mk(1,3,1,9, 0,0,0, 0,1,9, 0,1,32'hD000_0009, 0));
    tbl.push_back(mk(1,3,1,9, 0,0,0, 1,0,3, 1,0,32'hD000_0003, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,32'hD000_0009, 0));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 1,0,32'hD000_0003, 0));
    // A on addr 7 blocked by three writes to addr 7.
    tbl.push_back(mk(1,7,0,0, 1,7,W1, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,7,0,0, 1,7,W2, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(1,7,0,0, 1,7,W3, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,7,0,0, 0,0,0,  1,0,7, 0,0,0, 3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,0, 0,0,0, 3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,0, 1,0,W3, 3));
    // B alone with a write elsewhere, then preferred A collides so B wins.
    tbl.push_back(mk(0,0,1,2, 1,5,W5, 0,1,2, 0,0,0, 3));
    tbl.push_back(mk(1,7,1,2, 1,7,W4, 0,1,2, 0,0,0, 3));
    tbl.push_back(mk(1,7,0,0, 0,0,0,  1,0,7, 0,1,32'hD000_0002, 3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,0, 0,1,32'hD000_0002, 3));
    tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,0, 1,0,W4, 3));

    // Reset state, and combinational grant while reset is held.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_a", DW'(rsp_a), 0);
    chk("rst_rsp_b", DW'(rsp_b), 0);
    chk("rst_cnt", DW'(cnt), 0);
    drive(1, 5, 0, 0, 0, 0, 0);
    #1;
    chk("rst_comb_a_rdy", DW'(a_rdy), 1);
    chk("rst_comb_rd_en", DW'(rd_en), 1);
    chk("rst_comb_rd_addr", DW'(rd_addr), 5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].aa, tbl[i].bv, tbl[i].ba, tbl[i].we, tbl[i].wa, tbl[i].wd);
      #1;
      chk($sformatf("row%0d_a_rdy", i), DW'(a_rdy), DW'(tbl[i].ea));
      chk($sformatf("row%0d_b_rdy", i), DW'(b_rdy), DW'(tbl[i].eb));
      chk($sformatf("row%0d_rd_en", i), DW'(rd_en), DW'(tbl[i].ea | tbl[i].eb));
      chk($sformatf("row%0d_rd_addr", i), DW'(rd_addr), DW'(tbl[i].eaddr));
      chk($sformatf("row%0d_rsp_a", i), DW'(rsp_a), DW'(tbl[i].rsa));
      chk($sformatf("row%0d_rsp_b", i), DW'(rsp_b), DW'(tbl[i].rsb));
      if (tbl[i].rsa || tbl[i].rsb)
        chk($sformatf("row%0d_rsp_data", i), rsp_data, tbl[i].ed);
      chk($sformatf("row%0d_cnt", i), DW'(cnt), DW'(tbl[i].ecnt));
      chk($sformatf("row%0d_wr_pass", i), {mem_we, mem_wa, mem_wd[DW-8:0]},
          {tbl[i].we, tbl[i].wa, tbl[i].wd[DW-8:0]});
    end

    // Saturation: 3 + 20 stall cycles must clamp at 15, not wrap to 7.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1, 7, 0, 0, 1, 7, W6);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("sat_cnt", DW'(cnt), 15);
    // Clear wins over a simultaneous stall.
    @(negedge clk);
    drive(1, 7, 0, 0, 1, 7, W6);
    clr = 1'b1;
    #1;
    chk("clr_stall_a_rdy", DW'(a_rdy), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    clr = 1'b0;
    #1;
    chk("clr_cnt", DW'(cnt), 0);

    // Reset one cycle after a grant drops its response and returns prio to A.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_a_rdy", DW'(a_rdy), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_a", DW'(rsp_a), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 3, 1, 9, 0, 0, 0);
    #1;
    chk("post_rst_rsp_a", DW'(rsp_a), 0);
    chk("post_rst_a_rdy", DW'(a_rdy), 1);
    chk("post_rst_b_rdy", DW'(b_rdy), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_rsp_a2", DW'(rsp_a), 0);
    chk("post_rst_rsp_b2", DW'(rsp_b), 0);
    @(negedge clk);
    #1;
    chk("post_rst_rsp_a3", DW'(rsp_a), 1);
    chk("post_rst_rsp_data", rsp_data, 32'hD000_0003);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cacc_abuf_arbiter.md
# nv_nvdla_cacc_abuf_arbiter

Read-port arbiter and response router for the CACC assembly buffer SRAM. It shares the single abuf read port between two requesters: A, the accumulate read-modify-write path, and B, the delivery drain path. Arbitration is round-robin with read/write same-address collision avoidance. Each response is tagged and routed back to its requester two cycles after grant. The block sits between the CACC calc/delivery control and the assembly buffer; the write port passes straight through.

## Interface
- ABUF_AWIDTH, 6, abuf address width
- ABUF_WIDTH, 768, abuf data width
- CNT_WIDTH, 16, collision-stall counter width
- nvdla_core_clk  in  1  clock
- nvdla_core_rst  in  1  reset; asynchronous, active-high
- rd_a_valid / rd_b_valid  in  1  read request, requester A / B
- rd_a_addr / rd_b_addr  in  ABUF_AWIDTH  read address
- rd_a_ready / rd_b_ready  out  1  request granted this cycle
- wr_en  in  1  write request (always accepted)
- wr_addr  in  ABUF_AWIDTH  write address
- wr_data  in  ABUF_WIDTH  write data
- abuf_rd_en  out  1  to abuf read enable
- abuf_rd_addr  out  ABUF_AWIDTH  to abuf read address
- abuf_wr_en / abuf_wr_addr / abuf_wr_data  out  1 / ABUF_AWIDTH / ABUF_WIDTH  to abuf write port
- abuf_rd_data  in  ABUF_WIDTH  from abuf; valid 2 cycles after abuf_rd_en
- rsp_a_valid / rsp_b_valid  out  1  response valid for A / B
- rsp_data  out  ABUF_WIDTH  shared response data
- stall_cnt  out  CNT_WIDTH  saturating count of collision-stall cycles
- stall_cnt_clr  in  1  synchronous clear of stall_cnt

## Operation
- Write path is combinational pass-through: abuf_wr_en = wr_en, abuf_wr_addr = wr_addr, abuf_wr_data = wr_data.
- A request collides when wr_en = 1 and the request address equals wr_addr in the same cycle.
- Priority pointer prio (0 = A, 1 = B) is set to 0 on reset.
- Winner selection:
  - If both requesters are valid, the one named by prio is preferred.
  - If the preferred requester collides and the other is valid and non-colliding, the other is granted.
  - If every valid requester collides, nothing is granted.
- On a grant, prio is set to the opposite of the granted requester. With no grant, prio is held.
- rd_x_ready = grant_x, combinational, and is only asserted together with rd_x_valid. A requester holds valid and addr stable until ready.
- abuf_rd_en = grant_a | grant_b. abuf_rd_addr = the granted address, or 0 when idle.
- Tag pipe: 2 stages of {vld, id}. Stage 0 is loaded from {abuf_rd_en, grant_b}; stage 1 is loaded from stage 0.
  - rsp_a_valid = stage1.vld & ~stage1.id
  - rsp_b_valid = stage1.vld & stage1.id
  - rsp_data = abuf_rd_data (pass-through)
- There is no response backpressure. Requesters must always sink responses.
- stall_cnt increments when (rd_a_valid | rd_b_valid) and no grant is issued. It saturates at all-ones. stall_cnt_clr has priority over the increment.

## Timing
- Reset values: prio = 0; tag pipe cleared. Therefore rsp_a_valid = rsp_b_valid = 0 and stall_cnt = 0.
- Combinational outputs during reset follow their inputs: ready/abuf_rd_en depend only on valid/addr/wr inputs.
- Grant in cycle t gives the response in cycle t+2. One grant per cycle gives full throughput: back-to-back responses, one per cycle.
- Read in cycle t+1 of an address written in cycle t is legal and returns the new data, because the SRAM write completes at the edge.
- Reset asserted mid-operation: in-flight tags are dropped and no response is issued for them. Requesters re-issue after reset.
- A same-cycle read and write to different addresses are both issued.

## Test plan
- Only A valid, addr 5, 4 cycles, no writes -> rd_a_ready = 1 every cycle; rsp_a_valid at cycles 2-5; rsp_data = preloaded words at addr 5.
- A and B both continuously valid (addr 3, addr 9) -> grants alternate A, B, A, B…; rsp_a_valid and rsp_b_valid alternate starting 2 cycles later; stall_cnt stays 0.
- A valid addr 7, wr_en = 1 with wr_addr 7 for 3 cycles, then wr_en = 0 -> A is not ready for 3 cycles, granted in cycle 4, reads the written data; stall_cnt = 3.
- A addr 7 and B addr 2 with wr_addr 7 and prio = A -> B is granted and prio becomes A; the next cycle (no write) A is granted.
- stall_cnt forced near saturation (CNT_WIDTH = 4, 20 collision cycles) -> holds at 15; stall_cnt_clr asserted in the same cycle as a stall -> stall_cnt = 0.
- Reset pulsed 1 cycle after a grant -> no rsp_*_valid for that grant; prio = A after reset.
